// File: rtl/ccff_pkg.sv
// Shared definitions for ccff chain loaders.
// State encoding and the continuity marker bit.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        LOAD,
        DONE
    } ccff_state_e;

    localparam logic CCFF_MARKER = 1'b1;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream word stream into a ccff chain loader.
// Plain valid/ready handshake, one word per accepted cycle.
interface ccff_chain_loader_if #(
    parameter int DATA_W = 32
);

    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/ccff_word_serializer.sv
// Single-word buffer that feeds a ccff chain one bit per shift.
// Exposes next-cycle fullness and bit so the top can register its outputs.
module ccff_word_serializer
    import ccff_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                active,
    input  logic                last_bit,
    ccff_chain_loader_if.slave  cfg,
    output logic                shift,
    output logic                full_nxt,
    output logic                bit_nxt
);

    localparam int N_WORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int WRD_W   = $clog2(N_WORDS + 1);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] buf_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [WRD_W-1:0]  words_q;
    logic [WRD_W-1:0]  words_d;
    logic              full_q;
    logic              ready;
    logic              capture;
    logic              drain;

    // ready depends only on registers, never on cfg_valid
    assign ready   = active & ~full_q & (words_q < WRD_W'(N_WORDS));
    assign capture = cfg.cfg_valid & ready;
    assign shift   = active & full_q;
    assign drain   = shift
                   & ((idx_q == IDX_W'(DATA_W - 1)) | last_bit);

    assign cfg.cfg_ready = ready;

    always_comb begin
        buf_d    = buf_q;
        idx_d    = idx_q;
        words_d  = words_q;
        full_nxt = full_q;
        if (!active) begin
            idx_d    = '0;
            words_d  = '0;
            full_nxt = 1'b0;
        end else if (capture) begin
            buf_d    = cfg.cfg_data;
            idx_d    = '0;
            words_d  = words_q + WRD_W'(1);
            full_nxt = 1'b1;
        end else if (drain) begin
            idx_d    = '0;
            full_nxt = 1'b0;
        end else if (shift) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    assign bit_nxt = buf_d[idx_d];

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            buf_q   <= '0;
            idx_q   <= '0;
            words_q <= '0;
            full_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            full_q  <= full_nxt;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Flushes a marker through the ccff chain, then loads the bitstream
// while checking that the marker emerges at ccff_tail on time.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    ccff_chain_loader_if.slave  cfg,
    output logic                ccff_head,
    input  logic                ccff_tail,
    output logic                chain_clk_en,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    ccff_state_e      state_q;
    ccff_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             head_d;
    logic             en_d;
    logic             err_d;
    logic             exp_tail;
    logic             last_bit;
    logic             active;
    logic             shift;
    logic             full_nxt;
    logic             bit_nxt;

    assign last_bit = (cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign active   = (state_q == LOAD);

    ccff_word_serializer #(
        .DATA_W    (DATA_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_ser (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .active       (active),
        .last_bit     (last_bit),
        .cfg          (cfg),
        .shift        (shift),
        .full_nxt     (full_nxt),
        .bit_nxt      (bit_nxt)
    );

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ccff_head    <= head_d;
            chain_clk_en <= en_d;
            error        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                if (last_bit) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                if (shift) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_bit) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // head/enable are computed one cycle early so they leave a flop
    always_comb begin
        en_d     = 1'b0;
        head_d   = 1'b0;
        exp_tail = (cnt_q == '0) ? CCFF_MARKER : ~CCFF_MARKER;
        err_d    = error | (shift & (ccff_tail != exp_tail));
        if (state_q == IDLE && start) err_d = 1'b0;
        unique case (1'b1)
            (state_d == FLUSH): begin
                en_d   = 1'b1;
                head_d = (cnt_d == '0) ? CCFF_MARKER : ~CCFF_MARKER;
            end
            (state_d == LOAD): begin
                en_d   = full_nxt;
                head_d = full_nxt & bit_nxt;
            end
            default: ;
        endcase
    end

    assign busy = (state_q == FLUSH) | (state_q == LOAD);
    assign done = (state_q == DONE);

endmodule
